// File: rtl/uart_ctrl_pkg.sv
// Shared types and the round-robin pick function for the UART TX scheduler.
// Imported by the arbiter and the scheduler top.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    SENDING = 2'd2
  } sched_state_t;

  localparam int W_OUT_DEF         = 16;
  localparam int BITS_PER_WORD_DEF = 8;
  localparam int N_REQ_MAX         = 32;

  // First set bit of req at or after ptr, wrapping n_req-1 -> 0.
  // Scans from the far end so the nearest hit is the last one written.
  function automatic int rr_pick(input logic [N_REQ_MAX-1:0] req,
                                 input int                   n_req,
                                 input int                   ptr);
    int idx;
    rr_pick = ptr;
    for (int k = N_REQ_MAX - 1; k >= 0; k--) begin
      if (k < n_req) begin
        idx = ptr + k;
        if (idx >= n_req) idx = idx - n_req;
        if (req[idx[4:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant index from the priority pointer,
// pointer moves just past the winner whenever a grant is taken.
module rr_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [PW-1:0]    gid,
  output logic             any,
  output logic [PW-1:0]    ptr
);

  logic [N_REQ_MAX-1:0] req_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    gid                  = PW'(rr_pick(req_ext, N_REQ, int'(ptr)));
    any                  = |req;
  end

  // Explicit wrap keeps non-power-of-two requester counts legal.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gid == PW'(N_REQ - 1)) ? '0 : gid + PW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_rr_scheduler.sv
// Shares one UART transmitter between N_REQ requesters: round-robin capture,
// valid/ready issue to the UART, then a per-requester done pulse at frame end.
module uart_tx_rr_scheduler
  import uart_ctrl_pkg::*;
#(
  parameter  int N_REQ         = 4,
  parameter  int W_OUT         = W_OUT_DEF,
  parameter  int BITS_PER_WORD = BITS_PER_WORD_DEF,
  localparam int GW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_REQ-1:0]            req_en,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][W_OUT-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            req_done,
  output logic                        m_valid,
  output logic [W_OUT-1:0]            m_data,
  input  logic                        m_ready,
  output logic [GW-1:0]               grant_id,
  output logic                        busy
);

  if ((W_OUT % BITS_PER_WORD) != 0) begin : g_bad_width
    $error("W_OUT must be a multiple of BITS_PER_WORD");
  end

  sched_state_t     state;
  sched_state_t     state_next;
  logic             guard;
  logic [N_REQ-1:0] eligible;
  logic [GW-1:0]    arb_gid;
  logic [GW-1:0]    arb_ptr;
  logic             arb_any;
  logic             capture;

  assign eligible = req_valid & req_en;
  assign capture  = (state == IDLE) && arb_any;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (eligible),
    .advance (capture),
    .gid     (arb_gid),
    .any     (arb_any),
    .ptr     (arb_ptr)
  );

  always_ff @(posedge clk) begin
    if (rstn) assert (int'(arb_ptr) < N_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (arb_any)            state_next = ISSUE;
      ISSUE:   if (m_ready)            state_next = SENDING;
      SENDING: if (!guard && m_ready)  state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // The UART only lowers ready a cycle after acceptance, so the first
  // SENDING cycle must not treat a still-high m_ready as end of frame.
  always_comb begin
    req_ready = '0;
    req_done  = '0;
    m_valid   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (arb_any)           req_ready[arb_gid]  = 1'b1;
      ISSUE:                          m_valid             = 1'b1;
      SENDING: if (!guard && m_ready) req_done[grant_id]  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_data   <= '0;
      grant_id <= '0;
      guard    <= 1'b0;
    end else begin
      guard <= (state == ISSUE) && m_ready;
      if (capture) begin
        m_data   <= req_data[arb_gid];
        grant_id <= arb_gid;
      end
    end
  end

endmodule
